// File: rtl/sprite_engine.sv
// Single-sprite line engine: double-buffered registers, IDLE/DRAW/DONE scan FSM, registered pixel output.
// Optional feature: define SPRITE_COLLISION_EN for the sticky sprite/playfield collision flag.
module sprite_engine #(
  parameter int BIT_PIXELS = 4,
  parameter int X_MIN      = 96
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] address,
  input  logic [7:0] data_in,
  input  logic       write_enable,
  output logic [7:0] data_out,
  input  logic [9:0] hpos,
  input  logic       in_hblank,
  input  logic       playfield_pixel,
  output logic       sprite_on,
  output logic [7:0] sprite_color
);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, DONE = 2'd2} state_e;

  localparam int         CNT_W   = $clog2(BIT_PIXELS * 4 + 1);
  localparam logic [9:0] X_MIN_V = 10'(X_MIN);

  logic [7:0]       grp_p_q, grp_p_d, xlo_p_q, xlo_p_d, color_p_q, color_p_d;
  logic [1:0]       xhi_p_q, xhi_p_d;
  logic [2:0]       ctrl_p_q, ctrl_p_d;
  logic [7:0]       grp_a_q, grp_a_d, xlo_a_q, xlo_a_d, color_a_q, color_a_d;
  logic [1:0]       xhi_a_q, xhi_a_d;
  logic [2:0]       ctrl_a_q, ctrl_a_d;
  logic             hblank_q, hblank_d;
  state_e           state_q, state_d;
  logic [2:0]       bit_idx_q, bit_idx_d, disp_idx;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, pix_last;
  logic             sprite_on_q, sprite_on_d;
  logic [7:0]       data_out_q, data_out_d;
  logic [9:0]       x_act, start_x;
  logic             wr_en, rd_en, transfer, coll_rd;
  int               span;

  assign wr_en    = enable & write_enable;
  assign rd_en    = enable & ~write_enable;
  assign transfer = in_hblank & ~hblank_q;
  assign x_act    = {xhi_a_q, xlo_a_q};
  assign start_x  = (x_act < X_MIN_V) ? X_MIN_V : x_act;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grp_p_d   = grp_p_q;
    xlo_p_d   = xlo_p_q;
    xhi_p_d   = xhi_p_q;
    ctrl_p_d  = ctrl_p_q;
    color_p_d = color_p_q;
    hblank_d  = in_hblank;
    if (wr_en) begin
      case (address)
        3'd0:    grp_p_d   = data_in;
        3'd1:    xlo_p_d   = data_in;
        3'd2:    xhi_p_d   = data_in[1:0];
        3'd3:    ctrl_p_d  = data_in[2:0];
        3'd4:    color_p_d = data_in;
        default: ;
      endcase
    end
    // Forwarding the pending next-values lets a write landing on the transfer edge win.
    grp_a_d   = transfer ? grp_p_d   : grp_a_q;
    xlo_a_d   = transfer ? xlo_p_d   : xlo_a_q;
    xhi_a_d   = transfer ? xhi_p_d   : xhi_a_q;
    ctrl_a_d  = transfer ? ctrl_p_d  : ctrl_a_q;
    color_a_d = transfer ? color_p_d : color_a_q;
  end

  always_comb begin
    case (ctrl_a_q[2:1])
      2'b00:   span = BIT_PIXELS;
      2'b01:   span = BIT_PIXELS * 2;
      default: span = BIT_PIXELS * 4;
    endcase
    pix_last = CNT_W'(span - 1);
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    pix_cnt_d = pix_cnt_q;
    if (transfer) begin
      state_d   = IDLE;
      bit_idx_d = 3'd0;
      pix_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (!in_hblank && hpos == start_x) begin
          state_d   = DRAW;
          bit_idx_d = 3'd0;
          pix_cnt_d = '0;
        end
        DRAW: begin
          if (in_hblank) begin
            state_d = IDLE;
          end else if (pix_cnt_q == pix_last) begin
            pix_cnt_d = '0;
            if (bit_idx_q == 3'd7) state_d = DONE;
            else bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
        DONE:    ;
        default: state_d = IDLE;
      endcase
    end
    // The pixel is chosen from the post-transition position, so it appears one clock after its hpos.
    disp_idx    = ctrl_a_q[0] ? bit_idx_d : 3'd7 - bit_idx_d;
    sprite_on_d = (state_d == DRAW) && grp_a_q[disp_idx];
  end

`ifdef SPRITE_COLLISION_EN
  logic collision_q, collision_d;

  always_comb begin
    collision_d = collision_q;
    if (wr_en && address == 3'd5) collision_d = 1'b0;
    if (sprite_on_q && playfield_pixel) collision_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) collision_q <= 1'b0;
    else        collision_q <= collision_d;
  end

  assign coll_rd = collision_q;
`else
  logic pf_unused;
  assign pf_unused = playfield_pixel;
  assign coll_rd   = 1'b0;
`endif

  always_comb begin
    data_out_d = data_out_q;
    if (rd_en) begin
      case (address)
        3'd0:    data_out_d = grp_a_q;
        3'd1:    data_out_d = xlo_a_q;
        3'd2:    data_out_d = {6'b0, xhi_a_q};
        3'd3:    data_out_d = {5'b0, ctrl_a_q};
        3'd4:    data_out_d = color_a_q;
        3'd5:    data_out_d = {7'b0, coll_rd};
        3'd6:    data_out_d = {6'b0, state_q};
        default: data_out_d = 8'h00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grp_p_q     <= '0;
      xlo_p_q     <= '0;
      xhi_p_q     <= '0;
      ctrl_p_q    <= '0;
      color_p_q   <= '0;
      grp_a_q     <= '0;
      xlo_a_q     <= '0;
      xhi_a_q     <= '0;
      ctrl_a_q    <= '0;
      color_a_q   <= '0;
      hblank_q    <= 1'b0;
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      pix_cnt_q   <= '0;
      sprite_on_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      grp_p_q     <= grp_p_d;
      xlo_p_q     <= xlo_p_d;
      xhi_p_q     <= xhi_p_d;
      ctrl_p_q    <= ctrl_p_d;
      color_p_q   <= color_p_d;
      grp_a_q     <= grp_a_d;
      xlo_a_q     <= xlo_a_d;
      xhi_a_q     <= xhi_a_d;
      ctrl_a_q    <= ctrl_a_d;
      color_a_q   <= color_a_d;
      hblank_q    <= hblank_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      sprite_on_q <= sprite_on_d;
      data_out_q  <= data_out_d;
    end
  end

  assign data_out     = data_out_q;
  assign sprite_on    = sprite_on_q;
  assign sprite_color = color_a_q;

endmodule
